// File: rtl/conv_pkg.sv
// Shared types and helpers for the tiled convolution scheduler.
// The state encoding and window-range arithmetic are kept here so both counters and the FSM agree.
package conv_pkg;

    localparam int IDX_BITS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } sched_state_t;

    typedef logic [IDX_BITS-1:0] idx_t;

    // Last legal 3x3 window origin inside one sub-tile edge.
    function automatic int last_pos(input int size, input int totsub, input int ker);
        return (size / totsub) - ker;
    endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Three-level (filter, window row, window column) position counter.
// Column is fastest, then row, then filter; last flags the final position of the layer.
module conv_pos_counter
    import conv_pkg::*;
#(
    parameter int WIDTH_BIT = 16,
    parameter int FW        = 3,
    parameter int NW        = 4,
    parameter int LAST_POS  = last_pos(320, 16, 3)
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 clr,
    input  logic                 adv,
    input  logic [NW-1:0]        num,
    output logic [FW-1:0]        f,
    output logic [WIDTH_BIT-1:0] i,
    output logic [WIDTH_BIT-1:0] j,
    output logic                 last
);

    logic [WIDTH_BIT-1:0] lp;
    logic                 j_wrap;
    logic                 i_wrap;
    logic                 f_last;

    assign lp     = WIDTH_BIT'(LAST_POS);
    assign j_wrap = (j == lp);
    assign i_wrap = (i == lp);
    assign f_last = ((NW'(f) + NW'(1)) == num);
    assign last   = j_wrap && i_wrap && f_last;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            f <= '0;
            i <= '0;
            j <= '0;
        end else if (clr) begin
            f <= '0;
            i <= '0;
            j <= '0;
        end else if (adv) begin
            if (!j_wrap) begin
                j <= j + 1'b1;
            end else begin
                j <= '0;
                if (!i_wrap) begin
                    i <= i + 1'b1;
                end else begin
                    i <= '0;
                    f <= f + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/conv_tile_scheduler.sv
// Issues (f,i,j) window requests for one conv layer to the tiled engine under a credit limit
// and tags the in-order responses with their output position; pulses done after the last commit.
module conv_tile_scheduler
    import conv_pkg::*;
#(
    parameter int SIZE            = 320,
    parameter int SIZEKer         = 3,
    parameter int TOTSUBIMAGEM    = 16,
    parameter int WIDTH_BIT       = 16,
    parameter int MAX_FILTERS     = 8,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                             clock,
    input  logic                             nreset,
    input  logic                             start,
    input  logic                             abort,
    input  logic [$clog2(MAX_FILTERS+1)-1:0] cfg_num_filters,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic                             req_valid,
    input  logic                             req_ready,
    output logic [$clog2(MAX_FILTERS)-1:0]   req_f,
    output logic [WIDTH_BIT-1:0]             req_i,
    output logic [WIDTH_BIT-1:0]             req_j,
    input  logic                             rsp_valid,
    output logic                             cmt_we,
    output logic [$clog2(MAX_FILTERS)-1:0]   cmt_f,
    output logic [WIDTH_BIT-1:0]             cmt_i,
    output logic [WIDTH_BIT-1:0]             cmt_j
);

    localparam int FW       = $clog2(MAX_FILTERS);
    localparam int NW       = $clog2(MAX_FILTERS + 1);
    localparam int OW       = $clog2(MAX_OUTSTANDING + 1);
    localparam int LAST_POS = last_pos(SIZE, TOTSUBIMAGEM, SIZEKer);

    sched_state_t         state;
    sched_state_t         state_nxt;
    logic [NW-1:0]        num_filters;
    logic [OW-1:0]        outstanding;
    logic [WIDTH_BIT-1:0] orphans;

    logic                 hs;
    logic                 start_acc;
    logic                 rsp_take;
    logic                 rsp_stale;
    logic                 rsp_spur;
    logic                 fin_d;
    logic                 iss_last;
    logic                 cmt_last;
    logic                 ctr_clr;

    logic [FW-1:0]        pos_f;
    logic [WIDTH_BIT-1:0] pos_i;
    logic [WIDTH_BIT-1:0] pos_j;

    assign hs        = req_valid && req_ready;
    assign start_acc = (state == IDLE) && start && !abort;
    assign ctr_clr   = start_acc || abort;

    // Responses still owed from an aborted layer are swallowed silently before any new ones.
    assign rsp_stale = rsp_valid && (orphans != '0);
    assign rsp_take  = rsp_valid && (orphans == '0) && ((outstanding != '0) || hs);
    assign rsp_spur  = rsp_valid && (orphans == '0) && (outstanding == '0) && !hs;

    conv_pos_counter #(
        .WIDTH_BIT (WIDTH_BIT),
        .FW        (FW),
        .NW        (NW),
        .LAST_POS  (LAST_POS)
    ) u_issue_ctr (
        .clock  (clock),
        .nreset (nreset),
        .clr    (ctr_clr),
        .adv    (hs),
        .num    (num_filters),
        .f      (req_f),
        .i      (req_i),
        .j      (req_j),
        .last   (iss_last)
    );

    conv_pos_counter #(
        .WIDTH_BIT (WIDTH_BIT),
        .FW        (FW),
        .NW        (NW),
        .LAST_POS  (LAST_POS)
    ) u_commit_ctr (
        .clock  (clock),
        .nreset (nreset),
        .clr    (ctr_clr),
        .adv    (rsp_take),
        .num    (num_filters),
        .f      (pos_f),
        .i      (pos_i),
        .j      (pos_j),
        .last   (cmt_last)
    );

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = (cfg_num_filters == '0) ? FIN : ISSUE;
                    end
                end
                ISSUE: begin
                    if (hs && iss_last) begin
                        state_nxt = (rsp_take && cmt_last) ? FIN : DRAIN;
                    end
                end
                DRAIN: begin
                    if (rsp_take && cmt_last) begin
                        state_nxt = FIN;
                    end
                end
                FIN: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy      = 1'b0;
        req_valid = 1'b0;
        fin_d     = 1'b0;
        case (state)
            ISSUE: begin
                busy      = 1'b1;
                req_valid = (outstanding < OW'(MAX_OUTSTANDING));
            end
            DRAIN: begin
                busy = 1'b1;
            end
            FIN: begin
                fin_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Credit, orphan and status bookkeeping; commit tag is captured with the response.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            num_filters <= '0;
            outstanding <= '0;
            orphans     <= '0;
            err         <= 1'b0;
            done        <= 1'b0;
            cmt_we      <= 1'b0;
            cmt_f       <= '0;
            cmt_i       <= '0;
            cmt_j       <= '0;
        end else begin
            done   <= fin_d && !abort;
            cmt_we <= rsp_take && !abort;
            if (rsp_take) begin
                cmt_f <= pos_f;
                cmt_i <= pos_i;
                cmt_j <= pos_j;
            end
            if (start_acc) begin
                num_filters <= cfg_num_filters;
            end
            if (abort) begin
                outstanding <= '0;
                orphans     <= orphans - WIDTH_BIT'(rsp_stale) + WIDTH_BIT'(outstanding)
                               + WIDTH_BIT'(hs) - WIDTH_BIT'(rsp_take);
            end else begin
                outstanding <= outstanding + OW'(hs) - OW'(rsp_take);
                if (rsp_stale) begin
                    orphans <= orphans - 1'b1;
                end
            end
            if (rsp_spur) begin
                err <= 1'b1;
            end else if (start_acc) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed bench for conv_tile_scheduler with SIZE=8, TOTSUBIMAGEM=2, SIZEKer=3 (4 windows per filter).
module tb_conv_tile_scheduler;

    localparam int SIZE = 8;
    localparam int TOT  = 2;
    localparam int KER  = 3;
    localparam int WB   = 16;
    localparam int MAXF = 8;
    localparam int MAXO = 2;
    localparam int FW   = $clog2(MAXF);
    localparam int NW   = $clog2(MAXF + 1);

    logic          clock     = 1'b0;
    logic          nreset    = 1'b0;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic          req_ready = 1'b0;
    logic          inj_rsp   = 1'b0;
    logic [NW-1:0] cfg       = '0;
    logic          eng_rsp   = 1'b0;
    logic          rsp_valid;
    logic          busy, done, err, req_valid, cmt_we;
    logic [FW-1:0] req_f, cmt_f;
    logic [WB-1:0] req_i, req_j, cmt_i, cmt_j;

    int delay      = 1;
    int asserts    = 0;
    int fails      = 0;
    int ecnt       = 0;
    int done_cnt   = 0;
    int done_stamp = 0;
    int cmt_stamp  = 0;
    int rsp_cnt    = 0;
    int req_log[$];
    int cmt_log[$];
    int eng_q[$];

    assign rsp_valid = eng_rsp | inj_rsp;

    conv_tile_scheduler #(
        .SIZE            (SIZE),
        .SIZEKer         (KER),
        .TOTSUBIMAGEM    (TOT),
        .WIDTH_BIT       (WB),
        .MAX_FILTERS     (MAXF),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clock           (clock),
        .nreset          (nreset),
        .start           (start),
        .abort           (abort),
        .cfg_num_filters (cfg),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_f           (req_f),
        .req_i           (req_i),
        .req_j           (req_j),
        .rsp_valid       (rsp_valid),
        .cmt_we          (cmt_we),
        .cmt_f           (cmt_f),
        .cmt_i           (cmt_i),
        .cmt_j           (cmt_j)
    );

    always #5 clock = ~clock;

    function automatic int pcode(input int f, input int i, input int j);
        return f * 100 + i * 10 + j;
    endfunction

    // Expected tag of the p-th position with LAST_POS=1.
    function automatic int exp_code(input int p);
        return pcode(p / 4, (p / 2) % 2, p % 2);
    endfunction

    // Engine model: in-order responses 'delay' cycles after each handshake, plus logging.
    always @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            eng_q.delete();
            eng_rsp <= 1'b0;
        end else begin
            ecnt <= ecnt + 1;
            if (req_valid && req_ready) begin
                req_log.push_back(pcode(int'(req_f), int'(req_i), int'(req_j)));
                eng_q.push_back(ecnt + delay);
            end
            if (cmt_we) begin
                cmt_log.push_back(pcode(int'(cmt_f), int'(cmt_i), int'(cmt_j)));
                cmt_stamp <= ecnt;
            end
            if (done) begin
                done_cnt   <= done_cnt + 1;
                done_stamp <= ecnt;
            end
            if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
            if (eng_q.size() > 0 && eng_q[0] <= ecnt + 1) begin
                eng_rsp <= 1'b1;
                void'(eng_q.pop_front());
            end else begin
                eng_rsp <= 1'b0;
            end
        end
    end

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic test_reset;
        repeat (2) tick;
        asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
        asserts++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %0b want 0", done); end
        asserts++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %0b want 0", err); end
        asserts++; if (req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid got %0b want 0", req_valid); end
        asserts++; if (cmt_we !== 1'b0) begin fails++; $display("FAIL reset_cmt_we got %0b want 0", cmt_we); end
        asserts++; if ({req_f, req_i, req_j} !== '0) begin fails++; $display("FAIL reset_req_tag got %0d want 0", pcode(int'(req_f), int'(req_i), int'(req_j))); end
        asserts++; if ({cmt_f, cmt_i, cmt_j} !== '0) begin fails++; $display("FAIL reset_cmt_tag got %0d want 0", pcode(int'(cmt_f), int'(cmt_i), int'(cmt_j))); end
        nreset = 1'b1;
        tick;
        asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got %0b want 0", busy); end
    endtask

    task automatic test_basic;
        int rb, cb, db, nr, nc;
        delay = 1; req_ready = 1'b1;
        rb = req_log.size(); cb = cmt_log.size(); db = done_cnt;
        cfg = NW'(2); start = 1'b1;
        tick;
        start = 1'b0;
        asserts++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_c1 got %0b want 1", busy); end
        asserts++; if (req_valid !== 1'b1) begin fails++; $display("FAIL basic_valid_c1 got %0b want 1", req_valid); end
        for (int k = 0; k < 100 && done_cnt == db; k++) tick;
        repeat (3) tick;
        asserts++; if (done_cnt !== db + 1) begin fails++; $display("FAIL basic_done_count got %0d want %0d", done_cnt - db, 1); end
        asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after got %0b want 0", busy); end
        nr = req_log.size() - rb; nc = cmt_log.size() - cb;
        asserts++; if (nr !== 8) begin fails++; $display("FAIL basic_req_count got %0d want 8", nr); end
        asserts++; if (nc !== 8) begin fails++; $display("FAIL basic_cmt_count got %0d want 8", nc); end
        for (int p = 0; p < 8 && p < nr; p++) begin
            asserts++; if (req_log[rb+p] !== exp_code(p)) begin fails++; $display("FAIL basic_req_tag[%0d] got %0d want %0d", p, req_log[rb+p], exp_code(p)); end
        end
        for (int p = 0; p < 8 && p < nc; p++) begin
            asserts++; if (cmt_log[cb+p] !== exp_code(p)) begin fails++; $display("FAIL basic_cmt_tag[%0d] got %0d want %0d", p, cmt_log[cb+p], exp_code(p)); end
        end
        asserts++; if (done_stamp !== cmt_stamp + 1) begin fails++; $display("FAIL basic_done_latency got %0d want %0d", done_stamp - cmt_stamp, 1); end
    endtask

    task automatic test_credit;
        int rb, cb, db, rsb, issued, infl, drops, maxin, nc;
        logic expv;
        delay = 5; req_ready = 1'b1;
        rb = req_log.size(); cb = cmt_log.size(); db = done_cnt; rsb = rsp_cnt;
        drops = 0; maxin = 0;
        cfg = NW'(1); start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 200 && done_cnt == db; k++) begin
            issued = req_log.size() - rb;
            infl   = issued - (rsp_cnt - rsb);
            expv   = (issued < 4) && (infl < MAXO);
            if (infl > maxin) maxin = infl;
            if (!expv && issued < 4) drops++;
            asserts++; if (req_valid !== expv) begin fails++; $display("FAIL credit_valid cycle %0d got %0b want %0b (inflight %0d)", k + 1, req_valid, expv, infl); end
            tick;
        end
        asserts++; if (done_cnt !== db + 1) begin fails++; $display("FAIL credit_done got %0d want 1", done_cnt - db); end
        asserts++; if (maxin !== MAXO) begin fails++; $display("FAIL credit_max_inflight got %0d want %0d", maxin, MAXO); end
        asserts++; if (drops < 1) begin fails++; $display("FAIL credit_valid_drop got %0d want >=1", drops); end
        nc = cmt_log.size() - cb;
        asserts++; if (nc !== 4) begin fails++; $display("FAIL credit_cmt_count got %0d want 4", nc); end
        for (int p = 0; p < 4 && p < nc; p++) begin
            asserts++; if (cmt_log[cb+p] !== exp_code(p)) begin fails++; $display("FAIL credit_cmt_tag[%0d] got %0d want %0d", p, cmt_log[cb+p], exp_code(p)); end
        end
    endtask

    task automatic test_stall;
        int rb, cb, db, nr, nc;
        delay = 1; req_ready = 1'b1;
        rb = req_log.size(); cb = cmt_log.size(); db = done_cnt;
        cfg = NW'(1); start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        req_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            asserts++; if (req_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d] got %0b want 1", s, req_valid); end
            asserts++; if (pcode(int'(req_f), int'(req_i), int'(req_j)) !== 1) begin fails++; $display("FAIL stall_tag[%0d] got %0d want 1", s, pcode(int'(req_f), int'(req_i), int'(req_j))); end
            tick;
        end
        req_ready = 1'b1;
        for (int k = 0; k < 100 && done_cnt == db; k++) tick;
        asserts++; if (done_cnt !== db + 1) begin fails++; $display("FAIL stall_done got %0d want 1", done_cnt - db); end
        nr = req_log.size() - rb; nc = cmt_log.size() - cb;
        asserts++; if (nr !== 4) begin fails++; $display("FAIL stall_req_count got %0d want 4", nr); end
        asserts++; if (nc !== 4) begin fails++; $display("FAIL stall_cmt_count got %0d want 4", nc); end
        for (int p = 0; p < 4 && p < nr; p++) begin
            asserts++; if (req_log[rb+p] !== exp_code(p)) begin fails++; $display("FAIL stall_req_tag[%0d] got %0d want %0d", p, req_log[rb+p], exp_code(p)); end
        end
    endtask

    task automatic test_zero_cfg;
        int db;
        delay = 1; req_ready = 1'b1;
        db = done_cnt;
        cfg = NW'(0); start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy c%0d got %0b want 0", k, busy); end
            asserts++; if (req_valid !== 1'b0) begin fails++; $display("FAIL zero_valid c%0d got %0b want 0", k, req_valid); end
            asserts++; if (done !== (k == 2)) begin fails++; $display("FAIL zero_done c%0d got %0b want %0b", k, done, (k == 2)); end
            tick;
        end
        asserts++; if (done_cnt !== db + 1) begin fails++; $display("FAIL zero_done_count got %0d want 1", done_cnt - db); end
        inj_rsp = 1'b1;
        tick;
        inj_rsp = 1'b0;
        asserts++; if (err !== 1'b1) begin fails++; $display("FAIL spur_err got %0b want 1", err); end
        asserts++; if (cmt_we !== 1'b0) begin fails++; $display("FAIL spur_cmt_we got %0b want 0", cmt_we); end
        db = done_cnt;
        cfg = NW'(1); start = 1'b1;
        tick;
        start = 1'b0;
        asserts++; if (err !== 1'b0) begin fails++; $display("FAIL start_clears_err got %0b want 0", err); end
        for (int k = 0; k < 100 && done_cnt == db; k++) tick;
        asserts++; if (done_cnt !== db + 1) begin fails++; $display("FAIL zero_followup_done got %0d want 1", done_cnt - db); end
    endtask

    task automatic test_abort;
        int rb, cb, db, rsb, issued, infl, nr, nc;
        bit hit;
        delay = 5; req_ready = 1'b1;
        rb = req_log.size(); cb = cmt_log.size(); db = done_cnt; rsb = rsp_cnt;
        cfg = NW'(2); start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        req_ready = 1'b0;
        repeat (2) tick;
        req_ready = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            issued = req_log.size() - rb;
            infl   = issued - (rsp_cnt - rsb);
            if (issued == 3 && infl == 2) hit = 1'b1;
            else tick;
        end
        asserts++; if (hit !== 1'b1) begin fails++; $display("FAIL abort_setup got issued %0d inflight %0d want 3 and 2", issued, infl); end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %0b want 0", busy); end
        asserts++; if (req_valid !== 1'b0) begin fails++; $display("FAIL abort_valid got %0b want 0", req_valid); end
        cb = cmt_log.size();
        repeat (10) tick;
        asserts++; if (cmt_log.size() !== cb) begin fails++; $display("FAIL abort_late_cmt got %0d want 0", cmt_log.size() - cb); end
        asserts++; if (err !== 1'b0) begin fails++; $display("FAIL abort_late_err got %0b want 0", err); end
        asserts++; if (done_cnt !== db) begin fails++; $display("FAIL abort_no_done got %0d want 0", done_cnt - db); end
        delay = 1;
        rb = req_log.size(); cb = cmt_log.size(); db = done_cnt;
        cfg = NW'(1); start = 1'b1;
        tick;
        start = 1'b0;
        asserts++; if (pcode(int'(req_f), int'(req_i), int'(req_j)) !== 0) begin fails++; $display("FAIL abort_restart_tag got %0d want 0", pcode(int'(req_f), int'(req_i), int'(req_j))); end
        for (int k = 0; k < 100 && done_cnt == db; k++) tick;
        asserts++; if (done_cnt !== db + 1) begin fails++; $display("FAIL abort_restart_done got %0d want 1", done_cnt - db); end
        nr = req_log.size() - rb; nc = cmt_log.size() - cb;
        asserts++; if (nr !== 4) begin fails++; $display("FAIL abort_restart_reqs got %0d want 4", nr); end
        asserts++; if (nc !== 4) begin fails++; $display("FAIL abort_restart_cmts got %0d want 4", nc); end
        for (int p = 0; p < 4 && p < nc; p++) begin
            asserts++; if (cmt_log[cb+p] !== exp_code(p)) begin fails++; $display("FAIL abort_restart_cmt_tag[%0d] got %0d want %0d", p, cmt_log[cb+p], exp_code(p)); end
        end
    endtask

    task automatic test_reset_mid;
        int rb, cb, db, nr, nc;
        delay = 5; req_ready = 1'b1;
        rb = req_log.size();
        cfg = NW'(2); start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 100 && (req_log.size() - rb) < 8; k++) tick;
        asserts++; if (busy !== 1'b1) begin fails++; $display("FAIL midreset_in_drain got busy %0b want 1", busy); end
        #2 nreset = 1'b0;
        #1;
        asserts++; if ({busy, done, err, req_valid, cmt_we} !== 5'b0) begin fails++; $display("FAIL midreset_ctrl got %b want 00000", {busy, done, err, req_valid, cmt_we}); end
        asserts++; if ({req_f, req_i, req_j, cmt_f, cmt_i, cmt_j} !== '0) begin fails++; $display("FAIL midreset_tags got req %0d cmt %0d want 0", pcode(int'(req_f), int'(req_i), int'(req_j)), pcode(int'(cmt_f), int'(cmt_i), int'(cmt_j))); end
        repeat (2) tick;
        nreset = 1'b1;
        tick;
        delay = 1;
        rb = req_log.size(); cb = cmt_log.size(); db = done_cnt;
        cfg = NW'(2); start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 100 && done_cnt == db; k++) tick;
        repeat (2) tick;
        nr = req_log.size() - rb; nc = cmt_log.size() - cb;
        asserts++; if (done_cnt !== db + 1) begin fails++; $display("FAIL midreset_restart_done got %0d want 1", done_cnt - db); end
        asserts++; if (nr !== 8) begin fails++; $display("FAIL midreset_restart_reqs got %0d want 8", nr); end
        asserts++; if (nc !== 8) begin fails++; $display("FAIL midreset_restart_cmts got %0d want 8", nc); end
        asserts++; if (err !== 1'b0) begin fails++; $display("FAIL midreset_restart_err got %0b want 0", err); end
        for (int p = 0; p < 8 && p < nc; p++) begin
            asserts++; if (cmt_log[cb+p] !== exp_code(p)) begin fails++; $display("FAIL midreset_cmt_tag[%0d] got %0d want %0d", p, cmt_log[cb+p], exp_code(p)); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_credit();
        test_stall();
        test_zero_cfg();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
